// File: rtl/axi4_lite_interface.sv
// Bridges a core-side instruction/data request port onto an AXI4-Lite master.
// One transaction at a time; the data port wins over the instruction port.
module axi4_lite_interface #(
  parameter int unsigned data_width = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_req_o,
  output logic                    instr_gnt_i,
  output logic                    instr_rvalid_i,
  input  logic                    data_req_o,
  input  logic                    data_we_o,
  output logic                    data_gnt_i,
  output logic                    data_rvalid_i,
  input  logic [31:0]             Addr,
  input  logic [data_width-1:0]   Write_Data,
  output logic [data_width-1:0]   Read_Data,
  output logic                    AWvalid,
  input  logic                    AWready,
  output logic [31:0]             AWaddr,
  output logic                    Wvalid,
  input  logic                    Wready,
  output logic [data_width-1:0]   Wdata,
  output logic [data_width/8-1:0] Wstrb,
  input  logic                    Bvalid,
  output logic                    Bready,
  input  logic [1:0]              Bresp,
  output logic                    ARvalid,
  input  logic                    ARready,
  output logic [31:0]             ARaddr,
  input  logic                    Rvalid,
  output logic                    Rready,
  input  logic [data_width-1:0]   Rdata,
  input  logic [1:0]              Rresp
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = data_width / 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  src_instr_q, src_instr_d;
  logic                  arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic                  instr_gnt_d, instr_rvalid_d, data_gnt_d, data_rvalid_d;
  logic [ADDR_W-1:0]     araddr_d, awaddr_d;
  logic [data_width-1:0] wdata_d, read_data_d;
  logic [STRB_W-1:0]     wstrb_d;

  // Response codes carry no meaning for this bridge.
  logic unused_resp_c;
  assign unused_resp_c = ^{Rresp, Bresp};

  // Next-state and next-output decode; pulses default low, levels hold.
  always_comb begin
    state_d        = state_q;
    src_instr_d    = src_instr_q;
    arvalid_d      = ARvalid;
    araddr_d       = ARaddr;
    rready_d       = Rready;
    awvalid_d      = AWvalid;
    awaddr_d       = AWaddr;
    wvalid_d       = Wvalid;
    wdata_d        = Wdata;
    wstrb_d        = Wstrb;
    bready_d       = Bready;
    read_data_d    = Read_Data;
    instr_gnt_d    = 1'b0;
    instr_rvalid_d = 1'b0;
    data_gnt_d     = 1'b0;
    data_rvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req_o) begin
          src_instr_d = 1'b0;
          if (data_we_o) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = Addr;
            wdata_d   = Write_Data;
            wstrb_d   = '1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = Addr;
          end
        end else if (instr_req_o) begin
          src_instr_d = 1'b1;
          state_d     = RD_ADDR;
          arvalid_d   = 1'b1;
          araddr_d    = Addr;
        end
      end
      RD_ADDR: begin
        if (ARvalid && ARready) begin
          arvalid_d   = 1'b0;
          rready_d    = 1'b1;
          instr_gnt_d = src_instr_q;
          data_gnt_d  = !src_instr_q;
          state_d     = RD_DATA;
        end
      end
      RD_DATA: begin
        if (Rvalid && Rready) begin
          read_data_d    = Rdata;
          rready_d       = 1'b0;
          instr_rvalid_d = src_instr_q;
          data_rvalid_d  = !src_instr_q;
          state_d        = IDLE;
        end
      end
      WR_REQ: begin
        if (AWvalid && AWready) begin
          awvalid_d  = 1'b0;
          data_gnt_d = 1'b1;
        end
        if (Wvalid && Wready) wvalid_d = 1'b0;
        // Both channels finished, either earlier or on this edge.
        if ((!AWvalid || AWready) && (!Wvalid || Wready)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (Bvalid && Bready) begin
          bready_d      = 1'b0;
          data_rvalid_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      src_instr_q    <= 1'b0;
      ARvalid        <= 1'b0;
      ARaddr         <= '0;
      Rready         <= 1'b0;
      AWvalid        <= 1'b0;
      AWaddr         <= '0;
      Wvalid         <= 1'b0;
      Wdata          <= '0;
      Wstrb          <= '0;
      Bready         <= 1'b0;
      Read_Data      <= '0;
      instr_gnt_i    <= 1'b0;
      instr_rvalid_i <= 1'b0;
      data_gnt_i     <= 1'b0;
      data_rvalid_i  <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_instr_q    <= src_instr_d;
      ARvalid        <= arvalid_d;
      ARaddr         <= araddr_d;
      Rready         <= rready_d;
      AWvalid        <= awvalid_d;
      AWaddr         <= awaddr_d;
      Wvalid         <= wvalid_d;
      Wdata          <= wdata_d;
      Wstrb          <= wstrb_d;
      Bready         <= bready_d;
      Read_Data      <= read_data_d;
      instr_gnt_i    <= instr_gnt_d;
      instr_rvalid_i <= instr_rvalid_d;
      data_gnt_i     <= data_gnt_d;
      data_rvalid_i  <= data_rvalid_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_interface.sv
// Bench for axi4_lite_interface: directed scenarios plus random transactions,
// with expected per-cycle handshake timing derived from the slave delays.
module tb_axi4_lite_interface;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic          data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic [31:0]   Addr;
  logic [DW-1:0] Write_Data, Read_Data;
  logic          AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
  logic [31:0]   AWaddr, ARaddr;
  logic [DW-1:0] Wdata, Rdata;
  logic [DW/8-1:0] Wstrb;
  logic [1:0]    Bresp, Rresp, rresp_val;
  logic          ARvalid, ARready, Rvalid, Rready;

  int errors = 0;
  int checks = 0;

  axi4_lite_interface #(.data_width(DW)) dut (
    .clk(clk), .reset(reset),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .Addr(Addr), .Write_Data(Write_Data), .Read_Data(Read_Data),
    .AWvalid(AWvalid), .AWready(AWready), .AWaddr(AWaddr),
    .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
    .ARvalid(ARvalid), .ARready(ARready), .ARaddr(ARaddr),
    .Rvalid(Rvalid), .Rready(Rready), .Rdata(Rdata), .Rresp(Rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    AWready = 1'b0; Wready = 1'b0; Bvalid = 1'b0; ARready = 1'b0; Rvalid = 1'b0;
  endtask

  // One transaction. Read: d1 = AR wait, d2 = R wait. Write: d1 = AW wait,
  // d2 = W wait, d3 = B wait. Cycle k counts edges after the request edge.
  task automatic do_txn(input bit wr, input bit src_instr, input bit also_instr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int d1, input int d2, input int d3);
    int m, last;
    logic e_gnt, e_rv;
    Addr = addr;
    Write_Data = data;
    if (src_instr) begin
      instr_req_o = 1'b1; data_req_o = 1'b0;
    end else begin
      data_req_o = 1'b1; data_we_o = wr;
    end
    if (also_instr) instr_req_o = 1'b1;
    m = (d1 > d2) ? d1 : d2;
    last = wr ? 3 + m + d3 : 3 + d1 + d2;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      e_rv = (k == last);
      if (wr) begin
        e_gnt = (k == 2 + d1);
        chk_b("wr_awvalid", AWvalid, k <= 1 + d1);
        chk_b("wr_wvalid", Wvalid, k <= 1 + d2);
        chk_b("wr_bready", Bready, (k >= 2 + m) && (k <= 2 + m + d3));
        chk_b("wr_arvalid", ARvalid, 1'b0);
        chk_b("wr_rready", Rready, 1'b0);
        chk_b("wr_data_gnt", data_gnt_i, e_gnt);
        chk_b("wr_data_rvalid", data_rvalid_i, e_rv);
        chk_b("wr_instr_gnt", instr_gnt_i, 1'b0);
        chk_b("wr_instr_rvalid", instr_rvalid_i, 1'b0);
        if (k <= 1 + d1) chk_w("wr_awaddr", AWaddr, addr);
        if (k <= 1 + d2) begin
          chk_w("wr_wdata", Wdata, data);
          chk_w("wr_wstrb", 32'(Wstrb), 32'h0000_000F);
        end
        AWready = (k == 1 + d1);
        Wready  = (k == 1 + d2);
        Bvalid  = (k == 2 + m + d3);
        Bresp   = 2'($urandom);
      end else begin
        e_gnt = (k == 2 + d1);
        chk_b("rd_arvalid", ARvalid, k <= 1 + d1);
        chk_b("rd_rready", Rready, (k >= 2 + d1) && (k <= 2 + d1 + d2));
        chk_b("rd_awvalid", AWvalid, 1'b0);
        chk_b("rd_wvalid", Wvalid, 1'b0);
        chk_b("rd_bready", Bready, 1'b0);
        chk_b("rd_instr_gnt", instr_gnt_i, e_gnt && src_instr);
        chk_b("rd_data_gnt", data_gnt_i, e_gnt && !src_instr);
        chk_b("rd_instr_rvalid", instr_rvalid_i, e_rv && src_instr);
        chk_b("rd_data_rvalid", data_rvalid_i, e_rv && !src_instr);
        if (k <= 1 + d1) chk_w("rd_araddr", ARaddr, addr);
        if (e_rv) chk_w("rd_read_data", Read_Data, data);
        ARready = (k == 1 + d1);
        Rvalid  = (k == 2 + d1 + d2);
        Rdata   = (k == 2 + d1 + d2) ? data : $urandom;
        Rresp   = rresp_val;
      end
      if (k == 1) begin
        data_req_o = 1'b0;
        if (!also_instr) instr_req_o = 1'b0;
      end
      // Core inputs wander mid-transaction; they must be ignored.
      Addr = $urandom;
      Write_Data = $urandom;
      data_we_o = 1'($urandom);
    end
  endtask

  initial begin
    int kind;
    logic [31:0] a, d;
    reset = 1'b0;
    instr_req_o = 1'b0; data_req_o = 1'b0; data_we_o = 1'b0;
    Addr = '0; Write_Data = '0; Rdata = '0; Rresp = '0; Bresp = '0;
    rresp_val = 2'b00;
    slave_idle();
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_arvalid", ARvalid, 1'b0);
    chk_b("rst_awvalid", AWvalid, 1'b0);
    chk_b("rst_wvalid", Wvalid, 1'b0);
    chk_b("rst_rready", Rready, 1'b0);
    chk_b("rst_bready", Bready, 1'b0);
    chk_b("rst_gnt", instr_gnt_i | data_gnt_i, 1'b0);
    chk_b("rst_rvalid", instr_rvalid_i | data_rvalid_i, 1'b0);
    chk_w("rst_araddr", ARaddr, 32'h0);
    chk_w("rst_awaddr", AWaddr, 32'h0);
    chk_w("rst_wdata", Wdata, 32'h0);
    chk_w("rst_wstrb", 32'(Wstrb), 32'h0);
    chk_w("rst_read_data", Read_Data, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Instruction read, always-ready slave: minimum latency.
    do_txn(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_CCCC, 0, 0, 0);
    // Simultaneous requests: write first, then the still-pending instruction read.
    do_txn(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_CCCC, 0, 0, 0);
    do_txn(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, 0);
    // Write with W channel held off three cycles, and the reverse order.
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 0, 3, 0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0BAD_F00D, 2, 0, 1);
    // Slow read with an error response.
    rresp_val = 2'b10;
    do_txn(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'hCAFE_0001, 2, 2, 0);
    rresp_val = 2'b00;

    // Reset during RD_DATA aborts the read silently.
    Addr = 32'h0000_4000; instr_req_o = 1'b1;
    @(posedge clk); #1;
    chk_b("abort_arvalid", ARvalid, 1'b1);
    instr_req_o = 1'b0; ARready = 1'b1;
    @(posedge clk); #1;
    chk_b("abort_rready", Rready, 1'b1);
    chk_b("abort_gnt", instr_gnt_i, 1'b1);
    ARready = 1'b0; reset = 1'b0; Rvalid = 1'b1; Rdata = 32'h5555_AAAA; instr_req_o = 1'b1;
    @(posedge clk); #1;
    chk_b("abort_rready_clr", Rready, 1'b0);
    chk_b("abort_no_rvalid", instr_rvalid_i, 1'b0);
    chk_b("abort_gnt_clr", instr_gnt_i, 1'b0);
    chk_w("abort_read_data", Read_Data, 32'h0);
    chk_w("abort_araddr", ARaddr, 32'h0);
    @(posedge clk); #1;
    chk_b("abort_no_sample", ARvalid, 1'b0);
    chk_b("abort_no_rvalid2", instr_rvalid_i, 1'b0);
    Rvalid = 1'b0; reset = 1'b1;
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'h7777_1111, 1, 0, 0);

    // Random traffic against the timing model.
    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 2));
      a = $urandom;
      d = $urandom;
      rresp_val = 2'($urandom);
      do_txn(kind == 0, kind == 2, 1'b0, a, d,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        chk_b("idle_arvalid", ARvalid, 1'b0);
        chk_b("idle_awvalid", AWvalid, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
